// File: rtl/axis_checksum_append.sv
// axis_checksum_append
// Forwards every AXI-Stream packet unchanged through a single registered
// output slot. After the last data beat it adds one beat holding the
// two's-complement checksum, so all beats of the packet plus that beat sum
// to zero. TLAST is moved onto the checksum beat. The beat count of each
// completed packet is reported together with a one-cycle done pulse.
module axis_checksum_append #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  pkt_done,
  output logic [LEN_WIDTH-1:0]  pkt_len
);

  typedef enum logic {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic [DATA_WIDTH-1:0] r_sum;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [DATA_WIDTH-1:0] r_csum;
  logic [LEN_WIDTH-1:0]  r_finalLen;

  logic                  r_pktDone;
  logic [LEN_WIDTH-1:0]  r_pktLen;

  logic                  w_slotFree;
  logic                  w_sTready;
  logic                  w_accept;
  logic                  w_loadCsum;
  logic                  w_csumTaken;
  logic [DATA_WIDTH-1:0] w_sumNext;
  logic [LEN_WIDTH-1:0]  w_lenInc;

  // The slot can take a new beat when it is empty or is being drained this cycle.
  assign w_slotFree  = !r_tvalid || m_tready;
  assign w_accept    = s_tvalid && w_sTready;
  assign w_csumTaken = r_tvalid && m_tready && r_tlast;
  assign w_sumNext   = r_sum + s_tdata;
  assign w_lenInc    = (r_len == {LEN_WIDTH{1'b1}}) ? r_len : r_len + LEN_WIDTH'(1);

  assign s_tready = w_sTready;
  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign pkt_done = r_pktDone;
  assign pkt_len  = r_pktLen;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PASS;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: PASS streams data until TLAST; APPEND waits for the slot to free up.
  always_comb begin
    w_stateNext = r_state;
    w_sTready   = 1'b0;
    w_loadCsum  = 1'b0;
    case (r_state)
      PASS: begin
        w_sTready = w_slotFree;
        if (s_tvalid && w_slotFree && s_tlast) begin
          w_stateNext = APPEND;
        end
      end
      APPEND: begin
        if (w_slotFree) begin
          w_loadCsum  = 1'b1;
          w_stateNext = PASS;
        end
      end
      default: begin
        w_stateNext = PASS;
      end
    endcase
  end

  // Output slot: loads a data beat or the checksum, and empties on a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_tdata  <= s_tdata;
      r_tvalid <= 1'b1;
      r_tlast  <= 1'b0;
    end else if (w_loadCsum) begin
      r_tdata  <= r_csum;
      r_tvalid <= 1'b1;
      r_tlast  <= 1'b1;
    end else if (m_tready) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  // Running sum and length; the checksum and final length are captured on TLAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum      <= '0;
      r_len      <= '0;
      r_csum     <= '0;
      r_finalLen <= '0;
    end else if (w_accept) begin
      r_sum <= w_sumNext;
      r_len <= w_lenInc;
      if (s_tlast) begin
        r_csum     <= '0 - w_sumNext;
        r_finalLen <= w_lenInc;
      end
    end else if (w_loadCsum) begin
      r_sum <= '0;
      r_len <= '0;
    end
  end

  // Completion report, one cycle after the checksum beat is taken downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pktDone <= 1'b0;
      r_pktLen  <= '0;
    end else begin
      r_pktDone <= w_csumTaken;
      if (w_csumTaken) begin
        r_pktLen <= r_finalLen;
      end
    end
  end

endmodule

// File: tb/tb_axis_checksum_append.sv
// Testbench for axis_checksum_append.
// Packets are described as byte lists; the reference model derives the
// expected output stream (data beats followed by the negated byte sum) and
// the expected length report from those lists, and every cycle the DUT
// outputs are compared against it.
module tb_axis_checksum_append;

  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          pkt_done;
  logic [LW-1:0] pkt_len;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         inQ[$];
  beat_t         outQ[$];
  int            lenQ[$];
  logic [DW-1:0] pkt[$];

  int            checks = 0;
  int            errors = 0;
  int            cycleNo = 0;
  int            readyMode = 0;
  int            validMode = 0;
  int            sTreadyLowCnt = 0;
  logic          expectDone = 1'b0;
  logic [LW-1:0] expDoneLen = '0;
  logic [LW-1:0] modelLen = '0;
  logic          prevStall = 1'b0;

  axis_checksum_append #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tlast (s_tlast),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast (m_tlast),
    .pkt_done(pkt_done),
    .pkt_len (pkt_len)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the packet held in pkt; csumExp < 0 means derive the checksum from the bytes.
  task automatic addPacket(input int csumExp);
    int    total;
    int    n;
    beat_t b;
    total = 0;
    n = pkt.size();
    foreach (pkt[i]) begin
      b.d = pkt[i];
      b.l = (i == n - 1);
      inQ.push_back(b);
      b.l = 1'b0;
      outQ.push_back(b);
      total += int'(pkt[i]);
    end
    b.d = (csumExp >= 0) ? DW'(csumExp) : DW'((256 - (total % 256)) % 256);
    b.l = 1'b1;
    outQ.push_back(b);
    lenQ.push_back((n > 65535) ? 65535 : n);
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic applyStimulus();
    if (inQ.size() > 0) begin
      s_tvalid = (validMode == 0) || ($urandom_range(0, 3) != 0);
      s_tdata  = inQ[0].d;
      s_tlast  = inQ[0].l;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
    end
    case (readyMode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cycleNo % 2 == 0);
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    if (prevStall) checkOutput("stall_valid", 32'(m_tvalid), 32'd1);
    if (m_tvalid) begin
      if (outQ.size() == 0) begin
        checkOutput("unexpected_beat", 32'(m_tvalid), 32'd0);
      end else begin
        checkOutput("m_tdata", 32'(m_tdata), 32'(outQ[0].d));
        checkOutput("m_tlast", 32'(m_tlast), 32'(outQ[0].l));
      end
    end
    checkOutput("pkt_done", 32'(pkt_done), 32'(expectDone));
    if (expectDone) modelLen = expDoneLen;
    checkOutput("pkt_len", 32'(pkt_len), 32'(modelLen));
    if (!s_tready) sTreadyLowCnt++;
    expectDone = 1'b0;
    if (m_tvalid && m_tready && outQ.size() > 0) begin
      if (outQ[0].l) begin
        expectDone = 1'b1;
        expDoneLen = (lenQ.size() > 0) ? LW'(lenQ.pop_front()) : '0;
      end
      void'(outQ.pop_front());
    end
    prevStall = m_tvalid && !m_tready;
    if (s_tvalid && s_tready && inQ.size() > 0) void'(inQ.pop_front());
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  // Run cycles until every queued beat has been sent and checked, within a cycle budget.
  task automatic runDrain(input int maxCycles);
    int n;
    n = 0;
    while ((inQ.size() > 0 || outQ.size() > 0 || expectDone) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained", 32'(inQ.size() + outQ.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_m_tdata", 32'(m_tdata), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
    checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
    checkOutput("rst_pkt_len", 32'(pkt_len), 32'd0);
    checkOutput("rst_s_tready", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] basic packet 01 02 03");
    readyMode = 0; validMode = 0;
    pkt.delete(); pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
    addPacket(8'hFA);
    runDrain(50);
    checkOutput("len_after_p3", 32'(pkt_len), 32'd3);

    $display("[TB] single beat 80");
    pkt.delete(); pkt.push_back(8'h80);
    addPacket(8'h80);
    runDrain(50);
    checkOutput("len_after_p1", 32'(pkt_len), 32'd1);

    $display("[TB] wrap-around and zero packets");
    pkt.delete(); pkt.push_back(8'hFF); pkt.push_back(8'hFF);
    addPacket(8'h02);
    pkt.delete(); repeat (4) pkt.push_back(8'h00);
    addPacket(8'h00);
    runDrain(50);
    checkOutput("len_after_zero", 32'(pkt_len), 32'd4);

    $display("[TB] alternating m_tready over 5 beats");
    readyMode = 1;
    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(DW'($urandom_range(0, 255)));
    addPacket(-1);
    runDrain(100);
    checkOutput("len_after_alt", 32'(pkt_len), 32'd5);

    $display("[TB] back-to-back packets");
    readyMode = 0; validMode = 0;
    sTreadyLowCnt = 0;
    pkt.delete(); pkt.push_back(8'h10); pkt.push_back(8'h20);
    addPacket(8'hD0);
    pkt.delete(); pkt.push_back(8'h05);
    addPacket(8'hFB);
    runDrain(50);
    checkOutput("s_tready_low_cycles", 32'(sTreadyLowCnt), 32'd2);

    $display("[TB] randomized packets");
    for (int batch = 0; batch < 4; batch++) begin
      readyMode = (batch == 0) ? 0 : 2;
      validMode = (batch < 2) ? 0 : 1;
      for (int p = 0; p < 8; p++) begin
        pkt.delete();
        for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
          pkt.push_back(DW'($urandom_range(0, 255)));
        end
        addPacket(-1);
      end
      runDrain(2000);
    end

    $display("[TB] reset in the middle of a packet");
    readyMode = 0; validMode = 0;
    pkt.delete();
    pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC); pkt.push_back(8'hDD);
    addPacket(-1);
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    #1;
    checkOutput("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("midrst_m_tdata", 32'(m_tdata), 32'd0);
    checkOutput("midrst_m_tlast", 32'(m_tlast), 32'd0);
    checkOutput("midrst_pkt_done", 32'(pkt_done), 32'd0);
    checkOutput("midrst_pkt_len", 32'(pkt_len), 32'd0);
    checkOutput("midrst_s_tready", 32'(s_tready), 32'd1);
    inQ.delete(); outQ.delete(); lenQ.delete();
    expectDone = 1'b0; prevStall = 1'b0; modelLen = '0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pkt.delete(); pkt.push_back(8'h01);
    addPacket(8'hFF);
    runDrain(50);
    checkOutput("len_after_reset_pkt", 32'(pkt_len), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
